serial_tx_bitclk: RTL and testbench
===================================

// Module: serial_tx_bitclk
// PURPOSE
//  Serial frame transmitter downstream of the clock divider stage. Uses the divided
//  clock level (bit_clk, generated synchronously from clk) as its bit-rate reference:
//  one bit period = one bit_clk period (6 clk cycles with the divide-by-6 stage).
//  Accepts words via valid/ready; shifts out start, data LSB-first, optional parity, stop.
// PARAMETERS
//  DATA_W     8  data bits per frame, legal 5..9
//  PARITY_EN  0  1 = insert parity bit after data
//  PARITY_ODD 0  0 = even parity (^data), 1 = odd parity (~^data)
//  STOP_BITS  1  stop bits per frame, legal 1 or 2
// PORTS
//  clk        in   1       system clock, all logic on posedge
//  reset      in   1       asynchronous reset, active-low (asserted at 0)
//  bit_clk    in   1       divided clock level, synchronous to clk
//  tx_valid   in   1       upstream word valid
//  tx_data    in   DATA_W  word to send, sampled only on accept
//  tx_ready   out  1       high iff FSM in IDLE
//  tx         out  1       serial line, idle high, registered
//  busy       out  1       high iff FSM not in IDLE
//  frame_done out  1       1-cycle pulse when frame completes, registered
// BEHAVIOUR
//  Reset (reset=0, async): tx=1, frame_done=0, state=IDLE (tx_ready=1, busy=0),
//   bit_clk_q=1 (no spurious tick at release), shift reg/bit_idx/stop_cnt=0.
//  tick = bit_clk & ~bit_clk_q (bit_clk_q = bit_clk delayed 1 clk); one per bit_clk period.
//  Accept: posedge clk with tx_valid & tx_ready -> latch tx_data, compute parity, go ARM.
//   tx_data/tx_valid ignored outside IDLE; upstream holds its word.
//  FSM transitions and tx updates happen only on tick cycles (except accept):
//   IDLE   : tx=1; accept -> ARM.
//   ARM    : tick -> tx<=0, START.
//   START  : tick -> tx<=d[0], bit_idx<=0, DATA.
//   DATA   : tick & bit_idx<DATA_W-1 -> tx<=d[bit_idx+1], bit_idx++;
//            tick & last bit -> PARITY_EN ? (tx<=par, PARITY) : (tx<=1, stop_cnt<=0, STOP).
//   PARITY : tick -> tx<=1, stop_cnt<=0, STOP.
//   STOP   : tick & stop_cnt==STOP_BITS-1 -> IDLE, frame_done<=1; else stop_cnt++.
//  Each line bit lasts exactly one tick interval; tx changes 1 clk after the tick cycle.
//  Latency: accept -> start bit edge = wait for next tick (1..6 clk) + 1 clk.
//  Frame length 8N1 = 10 bit periods (60 clk) from start edge to return to IDLE.
//  Back-to-back: tx_ready rises cycle after final STOP tick; a word accepted then waits
//   in ARM for next tick, so consecutive frames are separated by one extra idle bit.
//  bit_clk stalled (no edges): FSM and tx freeze in current state indefinitely.
//  Reset mid-frame: frame dropped, tx forced 1 at once, no frame_done.
//  frame_done and accept may not coincide (accept only in IDLE, pulse on entry).
//  Illegal DATA_W/STOP_BITS: elaboration-time error ($error in generate check).
// TESTING
//  1 reset=0 mid-DATA -> tx=1, tx_ready=1, busy=0 same cycle; no frame_done after release.
//  2 bit_clk from div-6 stage, send 0xA5 8N1 -> tx = 0,1,0,1,0,0,1,0,1,1 each 6 clk;
//    one frame_done pulse; busy high for whole frame.
//  3 PARITY_EN=1: 0x07 even -> parity bit 1; PARITY_ODD=1 -> 0; 11 bit periods total.
//  4 STOP_BITS=2, 0xFF -> stop level held 12 clk before frame_done; tx_ready then 1.
//  5 tx_valid held, 0x3C then 0xC3; tx_data toggled during busy -> second frame carries
//    0xC3 exactly, accepted cycle after frame_done, 6-clk idle gap between frames.
//  6 bit_clk held constant 20 clk mid-DATA -> tx and state frozen; resumes bit order intact.

Source files
------------

// File: rtl/serial_tx_bitclk.sv
// serial_tx_bitclk
//   Serial frame transmitter paced by a divided bit clock level. A word is taken
//   over a valid/ready handshake and shifted out as: start bit (0), DATA_W data
//   bits LSB-first, an optional parity bit, then STOP_BITS stop bits (1).
//   One line bit lasts one bit_clk period; the line moves 1 clk after each
//   rising edge of bit_clk is seen.
//
// Ports
//   clk        in   system clock, all logic on posedge
//   reset      in   asynchronous reset, active-low
//   bit_clk    in   divided clock level, synchronous to clk
//   tx_valid   in   upstream word valid
//   tx_data    in   word to send (DATA_W bits), sampled only on accept
//   tx_ready   out  high iff the transmitter is idle
//   tx         out  serial line, idles high, registered
//   busy       out  high iff a frame is pending or in flight
//   frame_done out  one-cycle pulse after the last stop bit, registered
//   fsm_state  out  current FSM state, for debug/observation
//
// Handshake: a word is accepted on a posedge where tx_valid && tx_ready. The
//   upstream must hold tx_valid/tx_data until then; outside IDLE both inputs are
//   ignored, so they may change freely while busy.
module serial_tx_bitclk #(
    parameter int DATA_W     = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              bit_clk,
    input  logic              tx_valid,
    input  logic [DATA_W-1:0] tx_data,
    output logic              tx_ready,
    output logic              tx,
    output logic              busy,
    output logic              frame_done,
    output logic [2:0]        fsm_state
);

    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
        $error("serial_tx_bitclk: DATA_W must be in 5..9");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("serial_tx_bitclk: STOP_BITS must be 1 or 2");
    end

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_ARM    = 3'd1,
        S_START  = 3'd2,
        S_DATA   = 3'd3,
        S_PARITY = 3'd4,
        S_STOP   = 3'd5
    } state_t;

    localparam logic [3:0] LAST_IDX  = 4'(DATA_W - 1);
    localparam logic       LAST_STOP = 1'(STOP_BITS - 1);

    state_t            state;
    logic              bit_clk_q;
    logic              tick;
    logic [DATA_W-1:0] shreg;
    logic              par;
    logic [3:0]        bit_idx;
    logic              stop_cnt;

    // One tick per bit_clk period, on its rising level. bit_clk_q resets high so
    // a bit_clk that is already high at reset release does not tick.
    assign tick      = bit_clk & ~bit_clk_q;
    assign tx_ready  = (state == S_IDLE);
    assign busy      = (state != S_IDLE);
    assign fsm_state = state;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= S_IDLE;
            tx         <= 1'b1;
            frame_done <= 1'b0;
            bit_clk_q  <= 1'b1;
            shreg      <= '0;
            par        <= 1'b0;
            bit_idx    <= '0;
            stop_cnt   <= 1'b0;
        end else begin
            bit_clk_q  <= bit_clk;
            frame_done <= 1'b0;
            case (state)
                S_IDLE: begin
                    tx <= 1'b1;
                    if (tx_valid) begin
                        shreg <= tx_data;
                        par   <= (PARITY_ODD != 0) ? ~^tx_data : ^tx_data;
                        state <= S_ARM;
                    end
                end
                // Accept is not aligned to the bit grid: wait for the next tick
                // so the start bit gets a full bit period.
                S_ARM: begin
                    if (tick) begin
                        tx    <= 1'b0;
                        state <= S_START;
                    end
                end
                S_START: begin
                    if (tick) begin
                        tx      <= shreg[0];
                        bit_idx <= '0;
                        state   <= S_DATA;
                    end
                end
                // The word shifts right so the next data bit is always shreg[1].
                S_DATA: begin
                    if (tick) begin
                        if (bit_idx != LAST_IDX) begin
                            tx      <= shreg[1];
                            shreg   <= shreg >> 1;
                            bit_idx <= bit_idx + 4'd1;
                        end else if (PARITY_EN != 0) begin
                            tx    <= par;
                            state <= S_PARITY;
                        end else begin
                            tx       <= 1'b1;
                            stop_cnt <= 1'b0;
                            state    <= S_STOP;
                        end
                    end
                end
                S_PARITY: begin
                    if (tick) begin
                        tx       <= 1'b1;
                        stop_cnt <= 1'b0;
                        state    <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (tick) begin
                        if (stop_cnt == LAST_STOP) begin
                            state      <= S_IDLE;
                            frame_done <= 1'b1;
                        end else begin
                            stop_cnt <= stop_cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    tx    <= 1'b1;
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_serial_tx_bitclk.sv
// Testbench for serial_tx_bitclk. Six instances with different frame formats
// share one clock, reset and divide-by-6 bit clock. A frame-level model (a list
// of line bits advanced once per bit-clock rising edge) predicts tx, tx_ready,
// busy and frame_done every cycle; directed frames pin the model with literal
// line patterns and lengths.
module tb_serial_tx_bitclk;
  localparam int NI = 6;

  // Instance formats: 0 8N1, 1 8E1, 2 8N2, 3 8O1, 4 5E2, 5 9O2
  function automatic int cfg_w(input int i);
    case (i)
      4: return 5;
      5: return 9;
      default: return 8;
    endcase
  endfunction
  function automatic int cfg_par(input int i);
    return (i == 1 || i == 3 || i == 4 || i == 5) ? 1 : 0;
  endfunction
  function automatic int cfg_odd(input int i);
    return (i == 3 || i == 5) ? 1 : 0;
  endfunction
  function automatic int cfg_stop(input int i);
    return (i == 2 || i == 4 || i == 5) ? 2 : 1;
  endfunction

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic bit_clk = 1'b1;
  logic stall = 1'b0;
  int div = 0;

  always #5 clk = ~clk;

  // divide-by-6 bit clock, held while stall is set
  initial forever begin
    @(negedge clk);
    if (!stall) begin
      div = (div == 5) ? 0 : div + 1;
      bit_clk = (div < 3);
    end
  end

  // ---------------- DUTs ----------------
  logic [NI-1:0] tx_valid = '0;
  logic [8:0]    tx_data [NI];
  logic [NI-1:0] tx_ready, tx_line, busy, frame_done;
  logic [2:0]    fsm_state [NI];

  for (genvar g = 0; g < NI; g++) begin : g_dut
    serial_tx_bitclk #(
      .DATA_W(cfg_w(g)), .PARITY_EN(cfg_par(g)),
      .PARITY_ODD(cfg_odd(g)), .STOP_BITS(cfg_stop(g))
    ) u_dut (
      .clk(clk), .reset(reset), .bit_clk(bit_clk),
      .tx_valid(tx_valid[g]), .tx_data(tx_data[g][cfg_w(g)-1:0]),
      .tx_ready(tx_ready[g]), .tx(tx_line[g]), .busy(busy[g]),
      .frame_done(frame_done[g]), .fsm_state(fsm_state[g])
    );
  end

  // ---------------- scoreboard counters ----------------
  int n_cmp = 0;
  int n_bad = 0;
  logic [8:0] exp_q[$];

  task automatic chk_bit(input string nm, input int inst, input logic act, input logic exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      if (n_bad <= 40)
        $display("FAIL %s inst%0d t=%0t got=%b expected=%b state=%0d",
                 nm, inst, $time, act, exp, fsm_state[inst]);
    end
  endtask

  task automatic chk_int(input string nm, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s t=%0t got=0x%0h expected=0x%0h", nm, $time, act, exp);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Each accepted word becomes the list of line bits it must produce. Every
  // bit-clock rising edge seen while busy puts the next bit on the line; the
  // edge after the last bit ends the frame with a done pulse.
  logic [NI-1:0] m_tx = '1;
  logic [NI-1:0] m_busy = '0;
  logic [NI-1:0] m_done = '0;
  logic          m_prev = 1'b1;
  logic          m_tick;
  logic [15:0]   m_bits [NI];
  int            m_len [NI];
  int            m_pos [NI];

  task automatic build_frame(input int i);
    logic [15:0] bits;
    logic p;
    int n;
    bits = '0;
    p = 1'b0;
    n = 1;                      // bit 0 is the start bit (0)
    for (int b = 0; b < cfg_w(i); b++) begin
      bits[4'(n)] = tx_data[i][4'(b)];
      p = p ^ tx_data[i][4'(b)];
      n++;
    end
    if (cfg_par(i) != 0) begin
      bits[4'(n)] = (cfg_odd(i) != 0) ? ~p : p;
      n++;
    end
    for (int s = 0; s < cfg_stop(i); s++) begin
      bits[4'(n)] = 1'b1;
      n++;
    end
    m_bits[i] = bits;
    m_len[i] = n;
    m_pos[i] = 0;
  endtask

  initial forever begin
    @(posedge clk or negedge reset);
    if (!reset) begin
      m_prev = 1'b1;
      for (int i = 0; i < NI; i++) begin
        m_tx[i] = 1'b1;
        m_busy[i] = 1'b0;
        m_done[i] = 1'b0;
        m_len[i] = 0;
        m_pos[i] = 0;
      end
    end else begin
      m_tick = bit_clk & ~m_prev;
      for (int i = 0; i < NI; i++) begin
        m_done[i] = 1'b0;
        if (!m_busy[i]) begin
          if (tx_valid[i]) begin
            build_frame(i);
            m_busy[i] = 1'b1;
          end
        end else if (m_tick) begin
          if (m_pos[i] < m_len[i]) begin
            m_tx[i] = m_bits[i][4'(m_pos[i])];
            m_pos[i]++;
          end else begin
            m_busy[i] = 1'b0;
            m_tx[i] = 1'b1;
            m_done[i] = 1'b1;
          end
        end
      end
      m_prev = bit_clk;
    end
  end

  // ---------------- per-cycle compare ----------------
  initial forever begin
    @(negedge clk);
    #1;
    for (int i = 0; i < NI; i++) begin
      chk_bit("tx", i, tx_line[i], m_tx[i]);
      chk_bit("tx_ready", i, tx_ready[i], ~m_busy[i]);
      chk_bit("busy", i, busy[i], m_busy[i]);
      chk_bit("frame_done", i, frame_done[i], m_done[i]);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_busy(input int i);
    int g;
    g = 0;
    while (!busy[i] && g < 20) begin
      @(negedge clk);
      g++;
    end
    chk_int("accept_seen", int'(busy[i]), 1);
  endtask

  task automatic wait_start(input int i);
    int g;
    g = 0;
    while (tx_line[i] && g < 20) begin
      tx_data[i] = 9'($urandom_range(0, 511));
      @(negedge clk);
      g++;
    end
    chk_int("start_bit_seen", int'(tx_line[i]), 0);
  endtask

  // Called on the negedge where the start bit first shows; samples each bit
  // mid-period and stops on the negedge showing frame_done. len = clk cycles.
  task automatic capture_frame(input int i, output logic [15:0] seen,
                               output int len, output int busy_lo);
    int cnt;
    seen = '0;
    busy_lo = 0;
    cnt = 0;
    while (cnt < 200 && !frame_done[i]) begin
      if (!busy[i]) busy_lo++;
      if (cnt % 6 == 3) seen[4'(cnt / 6)] = tx_line[i];
      tx_data[i] = 9'($urandom_range(0, 511));
      @(negedge clk);
      cnt++;
    end
    len = cnt;
  endtask

  task automatic send_frame(input int i, input logic [8:0] word, output logic [15:0] seen,
                            output int len, output int busy_lo);
    @(negedge clk);
    tx_valid[i] = 1'b1;
    tx_data[i] = word;
    wait_busy(i);
    tx_valid[i] = 1'b0;
    wait_start(i);
    capture_frame(i, seen, len, busy_lo);
  endtask

  // ---------------- main sequence ----------------
  logic [15:0] seen;
  int len, busy_lo, gap, cnt_done, stall_left;
  logic ref_tx, frozen;
  logic [2:0] ref_st;

  initial begin
    for (int i = 0; i < NI; i++) tx_data[i] = '0;
    repeat (3) @(negedge clk);
    #1;
    chk_bit("reset_tx", 0, tx_line[0], 1'b1);
    chk_bit("reset_ready", 0, tx_ready[0], 1'b1);
    chk_bit("reset_busy", 0, busy[0], 1'b0);
    chk_bit("reset_done", 0, frame_done[0], 1'b0);
    @(negedge clk);
    reset = 1'b1;
    repeat (10) @(negedge clk);

    // 0xA5 8N1: line 0,1,0,1,0,0,1,0,1,1, 60 clk from start edge to done
    send_frame(0, 9'h0A5, seen, len, busy_lo);
    chk_int("a5_bits", int'(seen[9:0]), 'h34A);
    chk_int("a5_len", len, 60);
    chk_int("a5_busy_low", busy_lo, 0);

    // parity: 0x07 even -> parity 1, odd -> parity 0; 11 bit periods
    send_frame(1, 9'h007, seen, len, busy_lo);
    chk_int("07_even_bits", int'(seen[10:0]), 'h60E);
    chk_int("07_even_len", len, 66);
    send_frame(3, 9'h007, seen, len, busy_lo);
    chk_int("07_odd_bits", int'(seen[10:0]), 'h40E);
    chk_int("07_odd_len", len, 66);

    // two stop bits: 0xFF, stop level held 12 clk, ready at done
    send_frame(2, 9'h0FF, seen, len, busy_lo);
    chk_int("ff_2stop_bits", int'(seen[10:0]), 'h7FE);
    chk_int("ff_2stop_len", len, 66);
    chk_bit("ff_ready_at_done", 2, tx_ready[2], 1'b1);

    // width extremes
    send_frame(4, 9'h015, seen, len, busy_lo);
    chk_int("w5_bits", int'(seen[8:0]), 'h1EA);
    chk_int("w5_len", len, 54);
    send_frame(5, 9'h1FF, seen, len, busy_lo);
    chk_int("w9_bits", int'(seen[12:0]), 'h1BFE);
    chk_int("w9_len", len, 78);

    // back-to-back with tx_valid held and tx_data toggled while busy
    exp_q.push_back(9'h03C);
    exp_q.push_back(9'h0C3);
    @(negedge clk);
    tx_valid[0] = 1'b1;
    tx_data[0] = 9'h03C;
    wait_busy(0);
    wait_start(0);
    capture_frame(0, seen, len, busy_lo);
    chk_int("b2b_word1", int'(seen[8:1]), int'(exp_q.pop_front()));
    tx_data[0] = 9'h0C3;
    @(negedge clk);
    chk_bit("b2b_accept_after_done", 0, busy[0], 1'b1);
    tx_valid[0] = 1'b0;
    gap = 1;
    while (tx_line[0] && gap < 20) begin
      tx_data[0] = 9'($urandom_range(0, 511));
      @(negedge clk);
      gap++;
    end
    chk_int("b2b_idle_gap", gap, 6);
    capture_frame(0, seen, len, busy_lo);
    chk_int("b2b_word2", int'(seen[8:1]), int'(exp_q.pop_front()));
    chk_int("b2b_len2", len, 60);

    // bit_clk stalled 20 clk mid-data: line and state frozen, frame completes
    @(negedge clk);
    tx_valid[0] = 1'b1;
    tx_data[0] = 9'h05A;
    wait_busy(0);
    tx_valid[0] = 1'b0;
    wait_start(0);
    repeat (20) @(negedge clk);
    stall = 1'b1;
    repeat (2) @(negedge clk);
    ref_tx = tx_line[0];
    ref_st = fsm_state[0];
    frozen = 1'b1;
    repeat (18) begin
      @(negedge clk);
      if (tx_line[0] !== ref_tx || fsm_state[0] !== ref_st || !busy[0]) frozen = 1'b0;
    end
    chk_int("stall_frozen", int'(frozen), 1);
    stall = 1'b0;
    gap = 0;
    while (!frame_done[0] && gap < 200) begin
      @(negedge clk);
      gap++;
    end
    chk_bit("stall_resume_done", 0, frame_done[0], 1'b1);

    // reset mid-data: line high at once, no frame_done afterwards
    @(negedge clk);
    tx_valid[0] = 1'b1;
    tx_data[0] = 9'h033;
    wait_busy(0);
    tx_valid[0] = 1'b0;
    wait_start(0);
    repeat (20) @(negedge clk);
    reset = 1'b0;
    #1;
    chk_bit("midreset_tx", 0, tx_line[0], 1'b1);
    chk_bit("midreset_ready", 0, tx_ready[0], 1'b1);
    chk_bit("midreset_busy", 0, busy[0], 1'b0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    cnt_done = 0;
    repeat (80) begin
      @(negedge clk);
      if (frame_done[0]) cnt_done++;
    end
    chk_int("midreset_no_done", cnt_done, 0);

    // randomized traffic on all instances with bit_clk stalls and rare resets
    stall_left = 0;
    for (int c = 0; c < 4000; c++) begin
      @(negedge clk);
      for (int i = 0; i < NI; i++) begin
        tx_data[i] = 9'($urandom_range(0, 511));
        if (busy[i]) tx_valid[i] = 1'($urandom_range(0, 1));
        else tx_valid[i] = ($urandom_range(0, 3) != 0);
      end
      if (stall_left > 0) stall_left--;
      else if ($urandom_range(0, 199) == 0) stall_left = $urandom_range(1, 15);
      stall = (stall_left > 0);
      if (!reset) reset = 1'b1;
      else if ($urandom_range(0, 1499) == 0) reset = 1'b0;
    end
    @(negedge clk);
    tx_valid = '0;
    stall = 1'b0;
    reset = 1'b1;
    repeat (150) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog t=%0t simulation did not finish", $time);
    $fatal(1, "watchdog");
  end

endmodule
